// File: rtl/t07_fpu_mul_seq_if.sv
// t07_fpu_mul_seq_if: request/result bundle between the FPU control FSM and the sequential multiplier
interface t07_fpu_mul_seq_if #(parameter int WIDTH = 32);
  logic             en;
  logic [4:0]       op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;
  logic             sign;
  logic             overflow;
  logic             busy;
  logic             done;
  modport master (
    output en, op, inA, inB, signA, signB,
    input  product_hi, product_lo, sign, overflow, busy, done
  );
  modport slave (
    input  en, op, inA, inB, signA, signB,
    output product_hi, product_lo, sign, overflow, busy, done
  );
endinterface

// File: rtl/t07_fpu_mul_seq.sv
// t07_fpu_mul_seq: radix-2 shift-add unsigned multiplier, one partial-product bit per clock
module t07_fpu_mul_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] MUL_OP = 5'd6
) (
  input  logic               clk,
  input  logic               nrst,
  t07_fpu_mul_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic [WIDTH:0]    sum;
  logic              start, load, run, last;
  assign start = bus.en && bus.op == MUL_OP;
  assign run   = state_q == RUN;
  assign load  = start && !run;
  assign last  = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb state_d = run ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    bus.busy = run;
    bus.done = state_q == DONE;
  end
  // carry of the add is kept and shifted straight into the top of acc
  assign sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  always_comb begin
    acc_d    = load ? '0 : run ? sum[WIDTH:1] : acc_q;
    mplier_d = load ? bus.inB : run ? {sum[0], mplier_q[WIDTH-1:1]} : mplier_q;
    mcand_d  = load ? bus.inA : mcand_q;
    sign_d   = load ? bus.signA ^ bus.signB : sign_q;
    cnt_d    = load ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
    end
  assign bus.product_hi = acc_q;
  assign bus.product_lo = mplier_q;
  assign bus.overflow   = |acc_q;
  assign bus.sign       = sign_q & (|{acc_q, mplier_q});
endmodule
